// File: rtl/rvsteel_spi_stream_bridge.sv
// Byte-stream front end for the SPI controller: TX/RX FIFOs around a bus-master sequencer.
// Optional `SPI_BRIDGE_MODE_CFG_EN adds per-frame cpol/cpha/clock_div programming.
module rvsteel_spi_stream_bridge #(
    parameter logic [31:0] SPI_BASE   = 32'h9000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [7:0]  cs_index,
`ifdef SPI_BRIDGE_MODE_CFG_EN
    input  logic        cfg_cpol,
    input  logic        cfg_cpha,
    input  logic [7:0]  cfg_clock_div,
`endif
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  out_data,
    output logic        out_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] rw_address,
    input  logic [31:0] read_data,
    output logic        read_request,
    input  logic        read_response,
    output logic [31:0] write_data,
    output logic [3:0]  write_strobe,
    output logic        write_request,
    input  logic        write_response,
    output logic        frame_active
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

    localparam logic [31:0] OFF_CPOL = 32'h0000_0000;
    localparam logic [31:0] OFF_CPHA = 32'h0000_0004;
    localparam logic [31:0] OFF_CS   = 32'h0000_0008;
    localparam logic [31:0] OFF_DIV  = 32'h0000_000C;
    localparam logic [31:0] OFF_TX   = 32'h0000_0010;
    localparam logic [31:0] OFF_RX   = 32'h0000_0014;
    localparam logic [31:0] OFF_BUSY = 32'h0000_0018;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_CFG_CPOL  = 4'd1,
        S_CFG_CPHA  = 4'd2,
        S_CFG_DIV   = 4'd3,
        S_CS_WR     = 4'd4,
        S_TX_WR     = 4'd5,
        S_GAP       = 4'd6,
        S_BUSY_RD   = 4'd7,
        S_BUSY_HOLD = 4'd8,
        S_RX_GAP    = 4'd9,
        S_RX_RD     = 4'd10,
        S_PUSH      = 4'd11,
        S_CSOFF_WR  = 4'd12
    } state_t;

    state_t        state_r;
    logic          pending_r;
    logic [7:0]    cs_sel_r;
    logic [7:0]    byte_r;
    logic          last_r;

    logic [8:0]    tx_mem_r [FIFO_DEPTH];
    logic [AW-1:0] tx_wr_r, tx_rd_r;
    logic [AW:0]   tx_count_r;
    logic [8:0]    rx_mem_r [FIFO_DEPTH];
    logic [AW-1:0] rx_wr_r, rx_rd_r;
    logic [AW:0]   rx_count_r;

    logic          tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic [8:0]    tx_head_s, rx_head_s;
    logic          acc_wr_s, acc_rd_s, acc_issue_s, acc_done_s;
    logic [31:0]   acc_off_s, acc_data_s;
    logic          unused_s;

    assign in_ready  = (tx_count_r != DEPTH_C);
    assign out_valid = (rx_count_r != '0);
    assign tx_head_s = tx_mem_r[tx_rd_r];
    assign rx_head_s = rx_mem_r[rx_rd_r];
    assign out_data  = rx_head_s[7:0];
    assign out_last  = rx_head_s[8];
    assign tx_push_s = in_valid && in_ready;
    assign rx_pop_s  = out_valid && out_ready;
    assign tx_pop_s  = (state_r == S_TX_WR) && !pending_r;
    assign rx_push_s = (state_r == S_PUSH);
    assign unused_s  = ^read_data[31:8];

    // TX FIFO storage and occupancy
    always_ff @(posedge clock) begin
        if (reset) begin
            tx_wr_r    <= '0;
            tx_rd_r    <= '0;
            tx_count_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) tx_mem_r[i] <= 9'd0;
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_r] <= {in_last, in_data};
                tx_wr_r           <= tx_wr_r + AW'(1);
            end
            if (tx_pop_s) tx_rd_r <= tx_rd_r + AW'(1);
            case ({tx_push_s, tx_pop_s})
                2'b10:   tx_count_r <= tx_count_r + (AW + 1)'(1);
                2'b01:   tx_count_r <= tx_count_r - (AW + 1)'(1);
                default: tx_count_r <= tx_count_r;
            endcase
        end
    end

    // RX FIFO storage and occupancy; space is reserved before a byte starts, so no overflow check
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_wr_r    <= '0;
            rx_rd_r    <= '0;
            rx_count_r <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) rx_mem_r[i] <= 9'd0;
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wr_r] <= {last_r, byte_r};
                rx_wr_r           <= rx_wr_r + AW'(1);
            end
            if (rx_pop_s) rx_rd_r <= rx_rd_r + AW'(1);
            case ({rx_push_s, rx_pop_s})
                2'b10:   rx_count_r <= rx_count_r + (AW + 1)'(1);
                2'b01:   rx_count_r <= rx_count_r - (AW + 1)'(1);
                default: rx_count_r <= rx_count_r;
            endcase
        end
    end

    // Bus access implied by the current sequencer state
    always_comb begin
        acc_wr_s   = 1'b0;
        acc_rd_s   = 1'b0;
        acc_off_s  = 32'h0000_0000;
        acc_data_s = 32'h0000_0000;
        case (state_r)
`ifdef SPI_BRIDGE_MODE_CFG_EN
            S_CFG_CPOL: begin acc_wr_s = 1'b1; acc_off_s = OFF_CPOL; acc_data_s = {31'd0, cfg_cpol}; end
            S_CFG_CPHA: begin acc_wr_s = 1'b1; acc_off_s = OFF_CPHA; acc_data_s = {31'd0, cfg_cpha}; end
            S_CFG_DIV:  begin acc_wr_s = 1'b1; acc_off_s = OFF_DIV;  acc_data_s = {24'd0, cfg_clock_div}; end
`endif
            S_CS_WR:    begin acc_wr_s = 1'b1; acc_off_s = OFF_CS;   acc_data_s = {24'd0, cs_sel_r}; end
            S_TX_WR:    begin acc_wr_s = 1'b1; acc_off_s = OFF_TX;   acc_data_s = {24'd0, tx_head_s[7:0]}; end
            S_BUSY_RD:  begin acc_rd_s = 1'b1; acc_off_s = OFF_BUSY; end
            S_RX_RD:    begin acc_rd_s = 1'b1; acc_off_s = OFF_RX;   end
            S_CSOFF_WR: begin acc_wr_s = 1'b1; acc_off_s = OFF_CS;   acc_data_s = 32'h0000_00FF; end
            default:    begin acc_wr_s = 1'b0; acc_rd_s = 1'b0; end
        endcase
    end

    // Responses only count while our own access is outstanding
    assign acc_issue_s = (acc_wr_s || acc_rd_s) && !pending_r;
    assign acc_done_s  = pending_r && ((acc_wr_s && write_response) || (acc_rd_s && read_response));

    // Sequencer: one bus access in flight, walking the per-byte CS/TX/poll/RX flow
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= S_IDLE;
            pending_r     <= 1'b0;
            cs_sel_r      <= 8'd0;
            byte_r        <= 8'd0;
            last_r        <= 1'b0;
            frame_active  <= 1'b0;
            rw_address    <= SPI_BASE;
            write_data    <= 32'd0;
            write_strobe  <= 4'b0000;
            write_request <= 1'b0;
            read_request  <= 1'b0;
        end else begin
            write_request <= 1'b0;
            read_request  <= 1'b0;
            write_strobe  <= 4'b0000;
            if (acc_issue_s) begin
                pending_r     <= 1'b1;
                rw_address    <= SPI_BASE + acc_off_s;
                write_data    <= acc_data_s;
                write_request <= acc_wr_s;
                read_request  <= acc_rd_s;
                write_strobe  <= {4{acc_wr_s}};
            end else if (acc_done_s) begin
                pending_r <= 1'b0;
            end
            if (tx_pop_s) last_r <= tx_head_s[8];
            case (state_r)
                S_IDLE: begin
                    if (tx_count_r != '0 && rx_count_r < DEPTH_C) begin
                        if (frame_active) begin
                            state_r <= S_TX_WR;
                        end else begin
                            cs_sel_r <= cs_index;
`ifdef SPI_BRIDGE_MODE_CFG_EN
                            state_r  <= S_CFG_CPOL;
`else
                            state_r  <= S_CS_WR;
`endif
                        end
                    end
                end
`ifdef SPI_BRIDGE_MODE_CFG_EN
                S_CFG_CPOL:  if (acc_done_s) state_r <= S_CFG_CPHA;
                S_CFG_CPHA:  if (acc_done_s) state_r <= S_CFG_DIV;
                S_CFG_DIV:   if (acc_done_s) state_r <= S_CS_WR;
`endif
                S_CS_WR: begin
                    if (acc_done_s) begin
                        frame_active <= 1'b1;
                        state_r      <= S_TX_WR;
                    end
                end
                S_TX_WR:     if (acc_done_s) state_r <= S_GAP;
                S_GAP:       state_r <= S_BUSY_RD;
                S_BUSY_RD:   if (acc_done_s) state_r <= read_data[0] ? S_BUSY_HOLD : S_RX_GAP;
                S_BUSY_HOLD: state_r <= S_BUSY_RD;
                S_RX_GAP:    state_r <= S_RX_RD;
                S_RX_RD: begin
                    if (acc_done_s) begin
                        byte_r  <= read_data[7:0];
                        state_r <= S_PUSH;
                    end
                end
                S_PUSH:      state_r <= last_r ? S_CSOFF_WR : S_IDLE;
                S_CSOFF_WR: begin
                    if (acc_done_s) begin
                        frame_active <= 1'b0;
                        state_r      <= S_IDLE;
                    end
                end
                default:     state_r <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvsteel_spi_stream_bridge.sv
// Bench for rvsteel_spi_stream_bridge: behavioural loopback SPI peer on the bus side,
// scoreboards for bus writes and the RX stream, randomized frames and stalls.
module tb_rvsteel_spi_stream_bridge;

    localparam logic [31:0] BASE = 32'h9000_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  cs_index = 8'd0;
    logic [7:0]  in_data = 8'd0;
    logic        in_last = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] rw_address;
    logic [31:0] read_data;
    logic        read_request;
    logic        read_response;
    logic [31:0] write_data;
    logic [3:0]  write_strobe;
    logic        write_request;
    logic        write_response;
    logic        frame_active;
`ifdef SPI_BRIDGE_MODE_CFG_EN
    logic        cfg_cpol = 1'b1;
    logic        cfg_cpha = 1'b1;
    logic [7:0]  cfg_clock_div = 8'd3;
`endif

    rvsteel_spi_stream_bridge dut (
        .clock(clock), .reset(reset), .cs_index(cs_index),
`ifdef SPI_BRIDGE_MODE_CFG_EN
        .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_clock_div(cfg_clock_div),
`endif
        .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .rw_address(rw_address), .read_data(read_data), .read_request(read_request),
        .read_response(read_response), .write_data(write_data), .write_strobe(write_strobe),
        .write_request(write_request), .write_response(write_response), .frame_active(frame_active)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad = 0;

    logic [63:0] exp_wr[$];   // {address, data} of each expected bus write, in order
    logic [8:0]  exp_out[$];  // {last, byte} of each expected RX stream beat
    bit          in_frame = 1'b0;

    // peer state
    int          pend_kind = 0;  // 0 none, 1 write, 2 read
    int          pend_wait = 0;
    logic [31:0] pend_addr = 32'd0;
    int          busy_cnt = 0;
    int          busy_len = 0;
    logic [7:0]  tx_reg = 8'd0;
    logic [7:0]  rx_reg = 8'd0;
    int          busy_ones = 0;
    int          max_busy_ones = 0;
    int          tx_writes = 0;
    bit          saw_busy_rd = 1'b0;

    bit          rand_ready = 1'b0;
    logic        ready_hold = 1'b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic note_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: event seen, required none", name);
    endtask

    // Behavioural SPI controller peer: register file with loopback and a busy countdown
    initial begin
        write_response = 1'b0;
        read_response  = 1'b0;
        read_data      = 32'd0;
        forever begin
            @(posedge clock);
            #1;
            write_response = 1'b0;
            read_response  = 1'b0;
            read_data      = 32'd0;
            if (reset) begin
                pend_kind = 0;
                busy_cnt  = 0;
                busy_ones = 0;
                continue;
            end
            if (busy_cnt > 0) begin
                busy_cnt--;
                if (busy_cnt == 0) rx_reg = tx_reg;
            end
            if (pend_kind != 0) begin
                if (pend_wait == 0) begin
                    if (pend_kind == 1) begin
                        write_response = 1'b1;
                    end else begin
                        read_response = 1'b1;
                        if (pend_addr == BASE + 32'h18) begin
                            read_data = {31'd0, busy_cnt != 0};
                            if (busy_cnt != 0) busy_ones++;
                            saw_busy_rd = 1'b1;
                        end else if (pend_addr == BASE + 32'h14) begin
                            read_data = {24'd0, rx_reg};
                            if (busy_ones > max_busy_ones) max_busy_ones = busy_ones;
                        end else begin
                            read_data = 32'hDEAD_BEEF;
                            note_fail("read_bad_address");
                        end
                    end
                    pend_kind = 0;
                end else begin
                    pend_wait--;
                end
            end
            if (write_request || read_request) begin
                if (pend_kind != 0) note_fail("second_access_in_flight");
                pend_addr = rw_address;
                pend_wait = $urandom_range(0, 2);
                pend_kind = write_request ? 1 : 2;
            end
            if (write_request) begin
                logic [63:0] e;
                check("write_strobe", {28'd0, write_strobe}, 32'h0000_000F);
                if (exp_wr.size() == 0) begin
                    note_fail("unexpected_write");
                end else begin
                    e = exp_wr.pop_front();
                    check("write_addr", rw_address, e[63:32]);
                    check("write_data", write_data, e[31:0]);
                end
                if (rw_address == BASE + 32'h10) begin
                    tx_writes++;
                    tx_reg    = write_data[7:0];
                    busy_ones = 0;
                    busy_cnt  = busy_len;
                    if (busy_len == 0) rx_reg = tx_reg;
                end
            end
        end
    end

    // RX stream monitor: pops the scoreboard on every accepted beat
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && out_valid && out_ready) begin
                if (exp_out.size() == 0) begin
                    note_fail("unexpected_out");
                end else begin
                    logic [8:0] e;
                    e = exp_out.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, e[7:0]});
                    check("out_last", {31'd0, out_last}, {31'd0, e[8]});
                end
            end
        end
    end

    // out_ready driver
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_hold;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] d, input logic l);
        int n;
        if (!in_frame) begin
`ifdef SPI_BRIDGE_MODE_CFG_EN
            exp_wr.push_back({BASE + 32'h00, 32'd1});
            exp_wr.push_back({BASE + 32'h04, 32'd1});
            exp_wr.push_back({BASE + 32'h0C, 32'd3});
`endif
            exp_wr.push_back({BASE + 32'h08, {24'd0, cs_index}});
            in_frame = 1'b1;
        end
        exp_wr.push_back({BASE + 32'h10, {24'd0, d}});
        if (l) begin
            exp_wr.push_back({BASE + 32'h08, 32'h0000_00FF});
            in_frame = 1'b0;
        end
        exp_out.push_back({l, d});
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!in_ready && n < 3000);
        if (!in_ready) note_fail("in_ready_timeout");
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        rand_ready = 1'b0;
        ready_hold = 1'b1;
        n = 0;
        while ((exp_out.size() != 0 || exp_wr.size() != 0 || frame_active) && n < 5000) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("drain_out_left", exp_out.size(), 32'd0);
        check("drain_writes_left", exp_wr.size(), 32'd0);
        check("drain_frame_active", {31'd0, frame_active}, 32'd0);
    endtask

    initial begin
        int t0;
        int n;
        repeat (3) @(posedge clock);
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_frame_active", {31'd0, frame_active}, 32'd0);
        check("rst_rw_address", rw_address, BASE);
        check("rst_write_request", {31'd0, write_request}, 32'd0);
        check("rst_read_request", {31'd0, read_request}, 32'd0);
        check("rst_write_strobe", {28'd0, write_strobe}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'd0);
        reset = 1'b0;

        // single-byte frame on CS 0
        cs_index = 8'd0;
        send(8'hA5, 1'b1);
        drain();

        // three-byte frame: one CS select and one release
        cs_index = 8'd2;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        drain();

        // RX back-pressure: only FIFO_DEPTH transfers until the stream is drained
        cs_index   = 8'd1;
        ready_hold = 1'b0;
        @(posedge clock);
        #1;
        t0 = tx_writes;
        for (int i = 0; i < 6; i++) send(8'(8'h40 + i), i == 5);
        repeat (300) @(posedge clock);
        #1;
        check("stall_tx_count", tx_writes - t0, 32'd4);
        check("stall_out_valid", {31'd0, out_valid}, 32'd1);
        drain();
        check("stall_total_tx", tx_writes - t0, 32'd6);

        // long busy: several polls must see busy=1 before the RX read
        busy_len      = 20;
        max_busy_ones = 0;
        send(8'h5A, 1'b1);
        drain();
        check("busy_polls_ge2", {31'd0, max_busy_ones >= 2}, 32'd1);

        // randomized frames, busy times and out_ready
        cs_index   = 8'd3;
        rand_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            busy_len = $urandom_range(0, 4);
            send(8'($urandom), ($urandom_range(0, 2) == 0) || (i == 39));
        end
        drain();

        // reset during busy polling
        cs_index    = 8'd5;
        busy_len    = 40;
        saw_busy_rd = 1'b0;
        send(8'h77, 1'b0);
        n = 0;
        while (!saw_busy_rd && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("busy_poll_reached", {31'd0, saw_busy_rd}, 32'd1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("midrst_read_request", {31'd0, read_request}, 32'd0);
        check("midrst_write_request", {31'd0, write_request}, 32'd0);
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_frame_active", {31'd0, frame_active}, 32'd0);
        exp_out.delete();
        exp_wr.delete();
        in_frame = 1'b0;
        busy_len = 1;
        @(posedge clock);
        #1;
        reset = 1'b0;

        // recovery frame
        cs_index = 8'd0;
        send(8'h3C, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
